mesh_peek_ctrl: RTL
===================

MESH_PEEK_CTRL -- requirements
Module: mesh_peek_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- X, 3, mesh columns (1..16)
- Y, 3, mesh rows (1..16)
- ADDR_W, 32, peek address width
- DATA_W, 32, peek data width
- RD_LAT, 1, node RAM peek read latency in cycles (1..15)

REQ-002 Derived widths SHALL be:
- N = X*Y
- ID_W = max(1, clog2(N))
- ROW_W = max(1, clog2(Y))
- COL_W = max(1, clog2(X))

REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  peek request valid
- req_ready  out  1  controller can accept a request
- req_node  in  ID_W  linear node id
- req_addr  in  ADDR_W  word address inside the node RAM
- req_sweep  in  1  read req_addr from every node
- peek_addr  out  ADDR_W  address broadcast to all nodes
- peek_row  out  ROW_W  selected node row
- peek_col  out  COL_W  selected node column
- peek_data_in  in  N*DATA_W  node data, node n at bits [n*DATA_W +: DATA_W]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  DATA_W  read data
- rsp_node  out  ID_W  node that produced rsp_data
- rsp_err  out  1  request named a node >= N
- rsp_last  out  1  final response of the request

Function
REQ-004 Node mapping SHALL be: row = id / X, col = id % X, with node id = row*X + col.
REQ-005 FSM states SHALL be IDLE, WAIT and RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-007 On acceptance with req_node < N, the controller SHALL register peek_addr, peek_row and peek_col, load a delay counter with RD_LAT, and enter WAIT.
REQ-008 In WAIT the counter SHALL decrement at each edge.
REQ-009 At the edge where the counter equals 1, the controller SHALL capture the slice of peek_data_in for the current node into rsp_data and enter RESP.
REQ-010 rsp_valid SHALL therefore rise exactly RD_LAT cycles after the accept edge.
REQ-011 On acceptance with req_node >= N, the controller SHALL enter RESP at the next edge with rsp_err=1, rsp_data=0 and rsp_last=1.
REQ-012 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_node, rsp_err and rsp_last SHALL hold stable until an edge where rsp_ready is 1.
REQ-013 On that rsp_ready edge the controller SHALL return to IDLE, or continue the sweep per REQ-017.
REQ-014 peek_addr, peek_row and peek_col SHALL hold their last values while in IDLE.
REQ-015 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-016 When rst is asserted, the controller SHALL enter IDLE immediately, with no clock needed, and outputs SHALL be:
- req_ready = 1 once rst is released
- rsp_valid, rsp_err, rsp_last = 0
- rsp_data, rsp_node, peek_addr, peek_row, peek_col = 0
- delay counter = 0
An in-flight request or sweep SHALL be discarded without emitting a response.

Configuration
REQ-017 With macro MESH_PEEK_SWEEP_EN defined, an accepted request with req_sweep=1 SHALL ignore req_node and read req_addr from nodes 0..N-1 in ascending order.
- each node is a full WAIT/RESP pass
- rsp_last = 1 only for node N-1
- each RESP-to-WAIT transition reloads the counter with RD_LAT
REQ-018 Without MESH_PEEK_SWEEP_EN, req_sweep SHALL be ignored, every response SHALL have rsp_last=1, and no sweep logic SHALL be synthesised.

Structure
REQ-019 Package mesh_peek_pkg SHALL hold the FSM state enum and the width helper functions (clamped clog2).
REQ-020 A combinational sub-module mesh_node_decode SHALL map id to row, col and an in-range flag.
REQ-021 The controller itself SHALL be a single module with no further hierarchy.

Verification (X=3, Y=3, RD_LAT=2, DATA_W=32)
REQ-022 The bench SHALL cover the following directed scenarios:
- V1: node 5 preloaded with 0xCAFE0005 at address 0x10; request node 5, address 0x10 -> during WAIT peek_row=1, peek_col=2; rsp_valid rises 2 cycles after accept; rsp_data=0xCAFE0005, rsp_node=5, rsp_err=0, rsp_last=1.
- V2: request node 12 -> rsp_valid 1 cycle after accept; rsp_err=1, rsp_data=0, rsp_last=1.
- V3: rsp_ready held low 5 cycles during RESP -> rsp_valid and rsp_data stable throughout; req_ready=0; a req_valid pulse in that window is not accepted.
- V4: rst asserted asynchronously mid-WAIT -> rsp_valid=0, req_ready=1 and peek_row/peek_col=0 immediately; no response is emitted after release.
- V5 (MESH_PEEK_SWEEP_EN): sweep address 0x04 with node n holding n+0x100 -> 9 responses with rsp_node 0..8 and data 0x100..0x108; rsp_last=1 only on node 8.
- V6 (macro undefined): req_sweep=1, req_node=3 -> exactly one response, for node 3, with rsp_last=1.

Source files
------------

// File: rtl/mesh_peek_pkg.sv
// Shared types and width helpers for the mesh peek controller.
package mesh_peek_pkg;

   // Controller FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Delay counter width; RD_LAT is limited to 1..15
   localparam int CNT_W = 4;

   // clog2 clamped to a minimum of one bit so single-row/column meshes
   // still get a legal vector width
   function automatic int clog2c(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/mesh_node_decode.sv
// Combinational node-id decoder: linear id -> (row, col) plus in-range flag.
// id = row*X + col, so row = id / X and col = id % X.
module mesh_node_decode
   import mesh_peek_pkg::*;
#(
   parameter  int X     = 3,
   parameter  int Y     = 3,
   localparam int N     = X * Y,
   localparam int ID_W  = clog2c(N),
   localparam int ROW_W = clog2c(Y),
   localparam int COL_W = clog2c(X)
) (
   input  logic [ID_W-1:0]  i_id,
   output logic [ROW_W-1:0] o_row,
   output logic [COL_W-1:0] o_col,
   output logic             o_in_range
);

   logic [31:0] w_id;

   assign w_id = 32'(i_id);

   // Divide/modulo by a constant X; out-of-range ids give don't-care row/col
   always_comb begin
      o_row      = ROW_W'(w_id / 32'(X));
      o_col      = COL_W'(w_id % 32'(X));
      o_in_range = (w_id < 32'(N));
   end

endmodule

// File: rtl/mesh_peek_ctrl.sv
// Mesh peek controller: reads one word from a node RAM (or, with
// MESH_PEEK_SWEEP_EN defined, from every node in turn) and returns it
// through a valid/ready response channel. Node data is sampled RD_LAT
// cycles after the address is registered.
module mesh_peek_ctrl
   import mesh_peek_pkg::*;
#(
   parameter  int X      = 3,
   parameter  int Y      = 3,
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   parameter  int RD_LAT = 1,
   localparam int N      = X * Y,
   localparam int ID_W   = clog2c(N),
   localparam int ROW_W  = clog2c(Y),
   localparam int COL_W  = clog2c(X)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ID_W-1:0]     req_node,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                req_sweep,
   output logic [ADDR_W-1:0]   peek_addr,
   output logic [ROW_W-1:0]    peek_row,
   output logic [COL_W-1:0]    peek_col,
   input  logic [N*DATA_W-1:0] peek_data_in,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic [ID_W-1:0]     rsp_node,
   output logic                rsp_err,
   output logic                rsp_last
);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [ID_W-1:0]    r_node;
   logic [ADDR_W-1:0]  r_addr;
   logic [ROW_W-1:0]   r_row;
   logic [COL_W-1:0]   r_col;
   logic [DATA_W-1:0]  r_data;
   logic               r_err;
   logic               r_last;

   logic [ID_W-1:0]    w_dec_id;
   logic [ROW_W-1:0]   w_dec_row;
   logic [COL_W-1:0]   w_dec_col;
   logic               w_dec_ok;
   logic               w_accept;
   logic               w_capture;
   logic               w_advance;
   logic               w_more;
   logic               w_last_node;
   logic [ID_W-1:0]    w_sel;
   logic [DATA_W-1:0]  w_slice;

`ifdef MESH_PEEK_SWEEP_EN
   logic r_sweep;

   // Decoder sees the request in IDLE (node 0 for a sweep), else the next sweep node
   assign w_dec_id    = (r_state == IDLE) ? (req_sweep ? '0 : req_node)
                                          : (r_node + 1'b1);
   assign w_more      = r_sweep && !r_last;
   assign w_last_node = !r_sweep || (r_node == ID_W'(N - 1));

   // Remember whether the accepted request is a sweep
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_sweep <= 1'b0;
      else if (w_accept) r_sweep <= req_sweep;
   end
`else
   logic w_unused_sweep;

   assign w_unused_sweep = req_sweep;
   assign w_dec_id       = req_node;
   assign w_more         = 1'b0;
   assign w_last_node    = 1'b1;
`endif

   mesh_node_decode #(.X(X), .Y(Y)) u_decode (
      .i_id       (w_dec_id),
      .o_row      (w_dec_row),
      .o_col      (w_dec_col),
      .o_in_range (w_dec_ok)
   );

   // Bad node ids never index the data bus
   assign w_sel   = r_err ? '0 : r_node;
   assign w_slice = peek_data_in[int'(w_sel)*DATA_W +: DATA_W];

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next state and datapath strobes
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         IDLE: if (req_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: if (r_cnt == CNT_W'(1)) begin
            w_capture   = 1'b1;
            w_state_nxt = RESP;
         end
         RESP: if (rsp_ready) begin
            if (w_more) begin
               w_advance   = 1'b1;
               w_state_nxt = WAIT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: an out-of-range request waits a single cycle so it reaches
   // RESP one edge after acceptance without touching the peek outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_node <= '0;
         r_addr <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_data <= '0;
         r_err  <= 1'b0;
         r_last <= 1'b0;
      end else begin
         if (w_accept) begin
            r_node <= w_dec_id;
            r_err  <= !w_dec_ok;
            r_cnt  <= w_dec_ok ? CNT_W'(RD_LAT) : CNT_W'(1);
            if (w_dec_ok) begin
               r_addr <= req_addr;
               r_row  <= w_dec_row;
               r_col  <= w_dec_col;
            end
         end else if (w_advance) begin
            r_node <= w_dec_id;
            r_cnt  <= CNT_W'(RD_LAT);
            r_row  <= w_dec_row;
            r_col  <= w_dec_col;
         end else if (r_state == WAIT) begin
            r_cnt  <= r_cnt - 1'b1;
         end
         if (w_capture) begin
            r_data <= r_err ? '0 : w_slice;
            r_last <= r_err | w_last_node;
         end
      end
   end

   assign req_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = r_data;
   assign rsp_node  = r_node;
   assign rsp_err   = r_err;
   assign rsp_last  = r_last;
   assign peek_addr = r_addr;
   assign peek_row  = r_row;
   assign peek_col  = r_col;

endmodule
